// File: rtl/mov_pkg.sv
// rtl/mov_pkg.sv - shared state encoding and operand codes for the MOV controller
package mov_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SRC  = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [5:0] CODE_R0 = 6'd0;
  localparam logic [5:0] CODE_R1 = 6'd1;
  localparam logic [5:0] CODE_R2 = 6'd2;
  localparam logic [5:0] CODE_R3 = 6'd3;
  localparam logic [5:0] CODE_P0 = 6'd4;

endpackage

// File: rtl/mov_fsm_operand_decoder.sv
// rtl/mov_fsm_operand_decoder.sv - maps a 6-bit operand code to a one-hot {P0,R3,R2,R1,R0} strobe
module operand_decoder
  import mov_pkg::*;
(
  input  logic       en,
  input  logic [5:0] code,
  output logic [4:0] onehot
);

  // Unknown codes fall through the case and select nothing.
  always_comb begin
    onehot = 5'b00000;
    if (en) begin
      case (code)
        CODE_R0: onehot = 5'b00001;
        CODE_R1: onehot = 5'b00010;
        CODE_R2: onehot = 5'b00100;
        CODE_R3: onehot = 5'b01000;
        CODE_P0: onehot = 5'b10000;
        default: onehot = 5'b00000;
      endcase
    end
  end

endmodule

// File: rtl/mov_fsm.sv
// rtl/mov_fsm.sv - Moore controller for MOV Ri,Rj; strobes are registered from the next state
module mov_fsm
  import mov_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       donefetch,
  input  logic       start,
  output logic       done,
  output logic       Regjout,
  output logic       Regiin,
  input  logic [5:0] parameter1,
  input  logic [5:0] parameter2,
  output logic       r0in,
  output logic       r1in,
  output logic       r2in,
  output logic       r3in,
  output logic       P0in,
  output logic       R0OutEn,
  output logic       R1OutEn,
  output logic       R2OutEn,
  output logic       R3OutEn,
  output logic       P0OutEn
);

  state_t      state_q, state_d;
  logic [5:0]  src_q, src_d;
  logic [5:0]  dst_q, dst_d;
  logic        done_q, done_d;
  logic        regjout_q, regjout_d;
  logic        regiin_q, regiin_d;
  logic [4:0]  oe_q, oe_d;
  logic [4:0]  ie_q, ie_d;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SRC;
          src_d   = parameter2;
          dst_d   = parameter1;
        end
      end
      ST_SRC:  state_d = ST_XFER;
      ST_XFER: state_d = ST_DONE;
      ST_DONE: begin
        if (!start || donefetch) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered strobes line up with state_q.
  always_comb begin
    regjout_d = (state_d == ST_SRC) || (state_d == ST_XFER);
    regiin_d  = (state_d == ST_XFER);
    done_d    = (state_d == ST_DONE);
  end

  operand_decoder u_src_dec (
    .en     (regjout_d),
    .code   (src_d),
    .onehot (oe_d)
  );

  operand_decoder u_dst_dec (
    .en     (regiin_d),
    .code   (dst_d),
    .onehot (ie_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      src_q     <= 6'd0;
      dst_q     <= 6'd0;
      done_q    <= 1'b0;
      regjout_q <= 1'b0;
      regiin_q  <= 1'b0;
      oe_q      <= 5'b00000;
      ie_q      <= 5'b00000;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      done_q    <= done_d;
      regjout_q <= regjout_d;
      regiin_q  <= regiin_d;
      oe_q      <= oe_d;
      ie_q      <= ie_d;
    end
  end

  assign done    = done_q;
  assign Regjout = regjout_q;
  assign Regiin  = regiin_q;
  assign r0in    = ie_q[0];
  assign r1in    = ie_q[1];
  assign r2in    = ie_q[2];
  assign r3in    = ie_q[3];
  assign P0in    = ie_q[4];
  assign R0OutEn = oe_q[0];
  assign R1OutEn = oe_q[1];
  assign R2OutEn = oe_q[2];
  assign R3OutEn = oe_q[3];
  assign P0OutEn = oe_q[4];

endmodule

// File: tb/tb_mov_fsm.sv
// tb/tb_mov_fsm.sv - randomized and directed checks of mov_fsm against a step-count model
module tb_mov_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       donefetch = 1'b0;
  logic       start = 1'b0;
  logic [5:0] parameter1 = 6'd0;
  logic [5:0] parameter2 = 6'd0;
  logic done, Regjout, Regiin;
  logic r0in, r1in, r2in, r3in, P0in;
  logic R0OutEn, R1OutEn, R2OutEn, R3OutEn, P0OutEn;

  int compared = 0;
  int mismatched = 0;

  mov_fsm dut (
    .clk(clk), .rst(rst), .donefetch(donefetch), .start(start),
    .done(done), .Regjout(Regjout), .Regiin(Regiin),
    .parameter1(parameter1), .parameter2(parameter2),
    .r0in(r0in), .r1in(r1in), .r2in(r2in), .r3in(r3in), .P0in(P0in),
    .R0OutEn(R0OutEn), .R1OutEn(R1OutEn), .R2OutEn(R2OutEn), .R3OutEn(R3OutEn),
    .P0OutEn(P0OutEn)
  );

  always #5 clk = ~clk;

  // {done, Regjout, Regiin, in[P0,R3..R0], OutEn[P0,R3..R0]}
  logic [12:0] dut_vec;
  assign dut_vec = {done, Regjout, Regiin, P0in, r3in, r2in, r1in, r0in,
                    P0OutEn, R3OutEn, R2OutEn, R1OutEn, R0OutEn};

  // Model: cycles elapsed since the MOV was accepted (0 = idle, 1 = src, 2 = xfer, 3 = done).
  int m_step = 0;
  int m_src = 0;
  int m_dst = 0;
  bit m_valid = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_step = 0; m_src = 0; m_dst = 0;
    end else if (m_step == 0) begin
      if (start) begin
        m_step = 1; m_src = int'(parameter2); m_dst = int'(parameter1);
      end
    end else if (m_step < 3) begin
      m_step = m_step + 1;
    end else if (!start || donefetch) begin
      m_step = 0;
    end
    m_valid = 1;
  end

  function automatic logic [12:0] model_vec();
    logic [4:0] oe, ie;
    logic       drive, load;
    oe = 5'b0; ie = 5'b0;
    drive = (m_step == 1) || (m_step == 2);
    load  = (m_step == 2);
    if (drive && m_src < 5) oe = 5'b00001 << m_src;
    if (load && m_dst < 5) ie = 5'b00001 << m_dst;
    return {m_step == 3, drive, load, ie, oe};
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      compared++;
      if (dut_vec !== model_vec()) begin
        mismatched++;
        $display("FAIL model_cmp t=%0t dut=%b expected=%b", $time, dut_vec, model_vec());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input logic [12:0] exp);
    compared++;
    if (dut_vec !== exp) begin
      mismatched++;
      $display("FAIL %s dut=%b expected=%b", nm, dut_vec, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    tick(); tick();
    rst = 1'b0;
    chk("reset_idle", 13'b0_0_0_00000_00000);

    // MOV R0 <- R2, done held while start stays high
    parameter1 = 6'd0; parameter2 = 6'd2; start = 1'b1;
    tick(); chk("r0r2_src",  13'b0_1_0_00000_00100);
    tick(); chk("r0r2_xfer", 13'b0_1_1_00001_00100);
    tick(); chk("r0r2_done", 13'b1_0_0_00000_00000);
    tick(); chk("r0r2_hold", 13'b1_0_0_00000_00000);
    start = 1'b0;
    tick(); chk("r0r2_idle", 13'b0_0_0_00000_00000);

    // MOV P0 <- R3, released by donefetch with start still high
    parameter1 = 6'd4; parameter2 = 6'd3; start = 1'b1;
    tick(); chk("p0r3_src",  13'b0_1_0_00000_01000);
    tick(); chk("p0r3_xfer", 13'b0_1_1_10000_01000);
    tick(); chk("p0r3_done", 13'b1_0_0_00000_00000);
    donefetch = 1'b1;
    tick(); chk("p0r3_fetch_idle", 13'b0_0_0_00000_00000);
    start = 1'b0; donefetch = 1'b0;
    tick();

    // Invalid destination code
    parameter1 = 6'd9; parameter2 = 6'd1; start = 1'b1;
    tick(); chk("inv_src",  13'b0_1_0_00000_00010);
    tick(); chk("inv_xfer", 13'b0_1_1_00000_00010);
    start = 1'b0;
    tick(); chk("inv_done", 13'b1_0_0_00000_00000);
    tick(); chk("inv_idle", 13'b0_0_0_00000_00000);

    // Operand change after acceptance is ignored
    parameter1 = 6'd0; parameter2 = 6'd2; start = 1'b1;
    tick(); chk("chg_src", 13'b0_1_0_00000_00100);
    parameter2 = 6'd1; start = 1'b0;
    tick(); chk("chg_xfer", 13'b0_1_1_00001_00100);
    tick(); chk("chg_done", 13'b1_0_0_00000_00000);
    tick();

    // Reset during XFER
    parameter1 = 6'd1; parameter2 = 6'd3; start = 1'b1;
    tick(); chk("rstmid_src", 13'b0_1_0_00000_01000);
    tick(); chk("rstmid_xfer", 13'b0_1_1_00010_01000);
    rst = 1'b1; start = 1'b0;
    tick(); chk("rstmid_idle", 13'b0_0_0_00000_00000);
    rst = 1'b0;
    tick(); chk("rstmid_no_done", 13'b0_0_0_00000_00000);

    // Randomized traffic checked by the per-cycle model compare
    for (int i = 0; i < 2000; i++) begin
      start      = ($urandom_range(0, 3) != 0);
      donefetch  = ($urandom_range(0, 3) == 0);
      rst        = ($urandom_range(0, 59) == 0);
      parameter1 = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(5, 63)) : 6'($urandom_range(0, 4));
      parameter2 = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(5, 63)) : 6'($urandom_range(0, 4));
      tick();
    end
    rst = 1'b0; start = 1'b0; donefetch = 1'b0;
    tick(); tick(); tick(); tick();
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
